// File: rtl/btn_debounce.sv
// btn_debounce
//
// Per-channel switch conditioner that sits between the raw board switch pins
// and BTN_memory. Each channel synchronises its pin through two flops,
// rejects contact bounce with a stability counter, and produces a clean
// level plus single-cycle press and release pulses.
//
// Optional feature (compile-time macro BTN_DEBOUNCE_AUTOREPEAT_EN):
//   When defined, every channel gains an IDLE/DELAY/REPEAT FSM that emits
//   extra press pulses while a button stays held: the first one REPEAT_DELAY
//   cycles after the accepted press, then one every REPEAT_PERIOD cycles.
//   When undefined, press only marks debounced rising edges and the
//   REPEAT_* parameters have no effect.
//
// Parameters:
//   NUM_CH           number of independent switch channels
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a change (>= 2)
//   REPEAT_DELAY     hold time before the first auto-repeat pulse (macro only)
//   REPEAT_PERIOD    spacing of later auto-repeat pulses, >= 1 (macro only)
//
// Ports:
//   clk       in   system clock, all logic on the rising edge
//   reset     in   synchronous, active-high reset
//   switches  in   raw asynchronous switch / button inputs, one bit per channel
//   level     out  debounced switch state
//   press     out  one-cycle pulse on an accepted 0->1 change (plus repeats)
//   released  out  one-cycle pulse on an accepted 1->0 change
//                  ("release" is a reserved word, hence the past tense)
//
// Latency from the first edge that samples a new stable pin value to level
// changing is DEBOUNCE_CYCLES+2 edges: two synchroniser flops, then
// DEBOUNCE_CYCLES edges of agreement counted by cnt.

module btn_debounce #(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_PERIOD   = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] switches,
    output logic [NUM_CH-1:0] level,
    output logic [NUM_CH-1:0] press,
    output logic [NUM_CH-1:0] released
);

    localparam int               CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Synchroniser stages: switches -> s1 -> s
    logic [NUM_CH-1:0] s1;
    logic [NUM_CH-1:0] s;

    // Stability counters, one per channel
    logic [CNT_W-1:0]  cnt [NUM_CH];

    logic [NUM_CH-1:0] differ;
    logic [NUM_CH-1:0] at_last;
    logic [NUM_CH-1:0] accept_rise;
    logic [NUM_CH-1:0] accept_fall;
    logic [NUM_CH-1:0] press_next;

    // A change is accepted on the edge where the synchronised value still
    // disagrees with level and the counter has already seen DEBOUNCE_CYCLES-1
    // disagreeing edges before this one.
    always_comb begin
        differ  = '0;
        at_last = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            differ[i]  = s[i] ^ level[i];
            at_last[i] = (cnt[i] == CNT_LAST);
        end
        accept_rise = differ & at_last & s;
        accept_fall = differ & at_last & ~s;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1       <= '0;
            s        <= '0;
            level    <= '0;
            press    <= '0;
            released <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1       <= switches;
            s        <= s1;
            level    <= level ^ (accept_rise | accept_fall);
            press    <= press_next;
            released <= accept_fall;
            for (int i = 0; i < NUM_CH; i++) begin
                // Agreement with level (a bounce back) or an accepted change
                // both restart the count from zero.
                if (!differ[i] || at_last[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN

    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    logic [NUM_CH-1:0] rpt_fire;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_rpt
        rpt_state_t       state_q;
        rpt_state_t       state_d;
        logic [RPT_W-1:0] rcnt_q;
        logic [RPT_W-1:0] rcnt_d;
        logic             fire;

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= IDLE;
                rcnt_q  <= '0;
            end else begin
                state_q <= state_d;
                rcnt_q  <= rcnt_d;
            end
        end

        // The counter free-runs while a button is held; hitting the current
        // threshold fires one pulse and restarts it. An accepted release wins
        // over a coinciding threshold so no pulse escapes on that cycle.
        always_comb begin
            state_d = state_q;
            rcnt_d  = rcnt_q + RPT_W'(1);
            fire    = 1'b0;
            case (state_q)
                IDLE: begin
                    rcnt_d = '0;
                    if (accept_rise[i]) begin
                        state_d = DELAY;
                    end
                end
                DELAY: begin
                    if (accept_fall[i]) begin
                        state_d = IDLE;
                        rcnt_d  = '0;
                    end else if (rcnt_q == DELAY_LAST) begin
                        state_d = REPEAT;
                        rcnt_d  = '0;
                        fire    = 1'b1;
                    end
                end
                REPEAT: begin
                    if (accept_fall[i]) begin
                        state_d = IDLE;
                        rcnt_d  = '0;
                    end else if (rcnt_q == PERIOD_LAST) begin
                        rcnt_d = '0;
                        fire   = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    rcnt_d  = '0;
                end
            endcase
        end

        assign rpt_fire[i] = fire;
    end

    assign press_next = accept_rise | rpt_fire;

`else

    assign press_next = accept_rise;

    // Repeat timing only matters with auto-repeat compiled in; keep the
    // parameters referenced so the omission is clearly intentional.
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);

`endif

endmodule
